masked_affine_pipe: RTL



---
 rtl/masked_affine_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/masked_affine_pipe.sv
// masked_affine_pipe
//
// Pipelined 3-share affine layer for the masked Midori S-box datapath.
// Each share is mapped independently through a per-beat selectable affine
// map, either forward (L, with constant 9 on share 1), inverse (L^-1, with
// constant 6 on share 1) or bypass. The map is applied combinationally ahead
// of stage 0. After that, STAGES register stages with a valid/ready handshake
// carry the three shares to the output. The registered outputs serve as glitch
// barriers towards the round registers.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat present
//   in_ready   out  beat accepted this cycle (combinational through the chain)
//   mode       in   00 forward, 01 inverse, 10/11 bypass; sampled with beat
//   x1/x2/x3   in   input shares, nibble i at [4i+3:4i]
//   out_valid  out  output beat present
//   out_ready  in   downstream accepts
//   y1/y2/y3   out  output shares
module masked_affine_pipe #(
  parameter int NIBBLES = 16,
  parameter int STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [4*NIBBLES-1:0] x1,
  input  logic [4*NIBBLES-1:0] x2,
  input  logic [4*NIBBLES-1:0] x3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] y1,
  output logic [4*NIBBLES-1:0] y2,
  output logic [4*NIBBLES-1:0] y3
);

  localparam int W = 4 * NIBBLES;

  // Forward linear layer on one nibble.
  function automatic logic [3:0] lin_fwd(input logic [3:0] x);
    lin_fwd = {x[0] ^ x[2], x[3], x[3] ^ x[0], x[1]};
  endfunction

  // Inverse linear layer on one nibble.
  function automatic logic [3:0] lin_inv(input logic [3:0] y);
    lin_inv = {y[2], y[3] ^ y[1] ^ y[2], y[0], y[1] ^ y[2]};
  endfunction

  // Maps a single share. Only one share enters each call, so no logic cone
  // ever mixes shares; the constants are nonzero only for share 1.
  function automatic logic [W-1:0] map_share(
    input logic [W-1:0] x,
    input logic [1:0]   m,
    input logic [3:0]   k_fwd,
    input logic [3:0]   k_inv
  );
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < NIBBLES; i++) begin
      case (m)
        2'b00:   r[4*i +: 4] = lin_fwd(x[4*i +: 4]) ^ k_fwd;
        2'b01:   r[4*i +: 4] = lin_inv(x[4*i +: 4]) ^ k_inv;
        default: r[4*i +: 4] = x[4*i +: 4];
      endcase
    end
    return r;
  endfunction

  logic [W-1:0] m1, m2, m3;

  always_comb begin
    m1 = map_share(x1, mode, 4'h9, 4'h6);
    m2 = map_share(x2, mode, 4'h0, 4'h0);
    m3 = map_share(x3, mode, 4'h0, 4'h0);
  end

  // Stage state. The map is applied before stage 0, so mode does not need
  // to travel with the data.
  logic [STAGES-1:0] v;
  logic [W-1:0]      d1 [STAGES];
  logic [W-1:0]      d2 [STAGES];
  logic [W-1:0]      d3 [STAGES];

  // Per-stage upstream view and load enables.
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] up_v;
  logic [W-1:0]      up1 [STAGES];
  logic [W-1:0]      up2 [STAGES];
  logic [W-1:0]      up3 [STAGES];

  // A stage may load when it is empty or its content moves on this cycle;
  // the chain runs backwards from out_ready with no skid storage.
  always_comb begin
    logic chain;
    ld    = '0;
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain = ~v[k] | chain;
      ld[k] = chain;
    end
  end

  always_comb begin
    up_v = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        up_v[k] = in_valid;
        up1[k]  = m1;
        up2[k]  = m2;
        up3[k]  = m3;
      end else begin
        up_v[k] = v[k-1];
        up1[k]  = d1[k-1];
        up2[k]  = d2[k-1];
        up3[k]  = d3[k-1];
      end
    end
  end

  // Data registers capture only real beats; a bubble moves the valid bit
  // but leaves the share registers untouched, so no share is ever zeroed
  // mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d1[k] <= '0;
        d2[k] <= '0;
        d3[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= up_v[k];
          if (up_v[k]) begin
            d1[k] <= up1[k];
            d2[k] <= up2[k];
            d3[k] <= up3[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[STAGES-1];
  assign y1        = d1[STAGES-1];
  assign y2        = d2[STAGES-1];
  assign y3        = d3[STAGES-1];

endmodule
